// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes, funct3 encodings and operand bundle type
// Purpose: common definitions for the ALU operand stage and its register file.
// Contents: XLEN/NREGS, OP_REG/OP_IMM opcodes, funct3_e encodings, bundle_t,
//           imm_operand() helper for the I-type operand B.
package alu_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    typedef enum logic [2:0] {
        F3_ADD_SUB = 3'b000,
        F3_SLL     = 3'b001,
        F3_SLT     = 3'b010,
        F3_SLTU    = 3'b011,
        F3_XOR     = 3'b100,
        F3_SRL_SRA = 3'b101,
        F3_OR      = 3'b110,
        F3_AND     = 3'b111
    } funct3_e;

    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [2:0]      funct3;
        logic            funct7;
        logic [4:0]      rd;
        logic            illegal;
    } bundle_t;

    // Operand B for OP_IMM. Shift-immediates carry only the 6-bit shamt; the
    // SRAI selector bit (instr[30]) travels separately on funct7, so the ALU
    // sees a clean shift amount. All other I-types get sign-extended imm[11:0].
    function automatic logic [XLEN-1:0] imm_operand(input logic [31:0] instr);
        logic [XLEN-1:0] result;
        if (instr[14:12] == F3_SLL || instr[14:12] == F3_SRL_SRA) begin
            result = {{(XLEN-6){1'b0}}, instr[25:20]};
        end else begin
            result = {{(XLEN-12){instr[31]}}, instr[31:20]};
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 32x64 register file, two async read ports, one sync write port
// Purpose: architectural integer registers; x0 reads as zero and ignores writes.
// Ports: clk, rst (sync active-high, clears every register),
//        rs1_addr/rs1_data, rs2_addr/rs2_data (asynchronous reads),
//        wr_en/wr_addr/wr_data (write on rising edge).
// Config: ALU_OPERAND_FWD_EN adds a same-cycle write-to-read bypass.
module regfile_2r1w
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && wr_addr != 5'd0) begin
            regs[wr_addr] <= wr_data;
        end
    end

`ifdef ALU_OPERAND_FWD_EN
    assign rs1_data = (rs1_addr == 5'd0) ? '0 :
                      (wr_en && wr_addr == rs1_addr) ? wr_data : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 :
                      (wr_en && wr_addr == rs2_addr) ? wr_data : regs[rs2_addr];
`else
    assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - RV64 R/I-type decode and operand stage with busy scoreboard
// Purpose: decodes one ALU instruction per handshake, reads operands, stalls on
//          RAW hazards against in-flight destinations, registers the bundle.
// Ports: clk, rst (sync active-high); in_valid/in_ready/in_instr (instruction in);
//        out_valid/out_ready/out_rs1/out_rs2/out_funct3/out_funct7/out_rd/out_illegal
//        (registered operand bundle); wb_en/wb_rd/wb_data (writeback, clears busy).
// Config: ALU_OPERAND_FWD_EN enables same-cycle writeback bypass and hazard release.
module alu_operand_stage
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [2:0]      out_funct3,
    output logic            out_funct7,
    output logic [4:0]      out_rd,
    output logic            out_illegal,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    logic [6:0]      opcode;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [4:0]      rd_idx;
    logic [2:0]      funct3;
    logic            is_reg;
    logic            is_imm;
    logic            illegal;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [NREGS-1:0] busy;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            hazard;
    logic            accept;
    bundle_t         dec;
    bundle_t         out_q;

    assign opcode  = in_instr[6:0];
    assign rs1_idx = in_instr[19:15];
    assign rs2_idx = in_instr[24:20];
    assign rd_idx  = in_instr[11:7];
    assign funct3  = in_instr[14:12];
    assign is_reg  = (opcode == OP_REG);
    assign is_imm  = (opcode == OP_IMM);
    assign illegal = !(is_reg || is_imm);

    regfile_2r1w u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1_idx),
        .rs2_addr (rs2_idx),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val),
        .wr_en    (wb_en),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data)
    );

    // Busy lookups use the registered scoreboard, i.e. before this cycle's set.
`ifdef ALU_OPERAND_FWD_EN
    // A writeback landing this cycle is bypassed by the regfile, so its busy bit
    // no longer blocks the read.
    assign rs1_busy = (rs1_idx != 5'd0) && busy[rs1_idx] && !(wb_en && wb_rd == rs1_idx);
    assign rs2_busy = (rs2_idx != 5'd0) && busy[rs2_idx] && !(wb_en && wb_rd == rs2_idx);
`else
    assign rs1_busy = (rs1_idx != 5'd0) && busy[rs1_idx];
    assign rs2_busy = (rs2_idx != 5'd0) && busy[rs2_idx];
`endif

    assign hazard   = !illegal && (rs1_busy || (is_reg && rs2_busy));
    assign in_ready = !hazard && (!out_valid || out_ready);
    // An instruction presented during reset is dropped.
    assign accept   = in_valid && in_ready && !rst;

    // Illegal opcodes are forwarded as if R-type so the consumer sees raw fields.
    always_comb begin
        dec         = '0;
        dec.rs1     = rs1_val;
        dec.rs2     = is_imm ? imm_operand(in_instr) : rs2_val;
        dec.funct3  = funct3;
        dec.funct7  = is_imm ? (in_instr[30] && funct3 == F3_SRL_SRA) : in_instr[30];
        dec.rd      = rd_idx;
        dec.illegal = illegal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (wb_en && wb_rd != 5'd0) begin
                busy[wb_rd] <= 1'b0;
            end
            // Placed after the clear so a same-index set in the same cycle wins.
            if (accept && !illegal && rd_idx != 5'd0) begin
                busy[rd_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_q     <= dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_funct3  = out_q.funct3;
    assign out_funct7  = out_q.funct7;
    assign out_rd      = out_q.rd;
    assign out_illegal = out_q.illegal;

endmodule
